// File: rtl/ip_tile_csr_bank_if.sv
// Bus interface for ip_tile_csr_bank.
// Single-cycle request/response bus:
//   bus_req/bus_we/bus_addr/bus_wdata : request, driven by the master
//   bus_gnt                           : acceptance, driven by the slave
//   bus_rvalid/bus_rdata/bus_err      : registered response, driven by the slave
interface ip_tile_csr_bank_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int REG_WIDTH  = 32
);
    logic                  bus_req;
    logic                  bus_we;
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic [REG_WIDTH-1:0]  bus_wdata;
    logic                  bus_gnt;
    logic                  bus_rvalid;
    logic [REG_WIDTH-1:0]  bus_rdata;
    logic                  bus_err;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata, bus_err
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata, bus_err
    );
endinterface

// File: rtl/ip_tile_csr_bank.sv
// Register bank in front of the ip_tile_fsm_bitwise_shifter tile.
// Holds the command CSR and the two operands driven into the tile, shadows the
// tile status, and exposes the tile result for reads.
// Ports:
//   clk, arst_n            : clock, asynchronous active-low reset
//   bus                    : slave side of the CSR bus (ip_tile_csr_bank_if)
//   csr_in / csr_in_re     : command CSR to the tile, tile read strobe
//   data_reg_a/data_reg_b  : operands to the tile
//   csr_out / csr_out_we   : status from the tile and its write strobe
//   data_reg_c             : result from the tile (read live)
//   irq                    : set while any of status bits [3:0] is pending
// Map: 0x0 CSR_IN RW, 0x1 CSR_OUT RO (bits [3:0] clear-on-read),
//      0x2 DATA_A RW, 0x3 DATA_B RW, 0x4 DATA_C RO, others unmapped.
module ip_tile_csr_bank #(
    parameter int CSR_IN_WIDTH  = 16,
    parameter int CSR_OUT_WIDTH = 16,
    parameter int REG_WIDTH     = 32,
    parameter int ADDR_WIDTH    = 4
) (
    input  logic                     clk,
    input  logic                     arst_n,
    ip_tile_csr_bank_if.slave        bus,
    output logic [CSR_IN_WIDTH-1:0]  csr_in,
    input  logic                     csr_in_re,
    output logic [REG_WIDTH-1:0]     data_reg_a,
    output logic [REG_WIDTH-1:0]     data_reg_b,
    input  logic [CSR_OUT_WIDTH-1:0] csr_out,
    input  logic                     csr_out_we,
    input  logic [REG_WIDTH-1:0]     data_reg_c,
    output logic                     irq
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_CSR_IN  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] ADDR_CSR_OUT = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA_A  = ADDR_WIDTH'(2);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA_B  = ADDR_WIDTH'(3);
    localparam logic [ADDR_WIDTH-1:0] ADDR_DATA_C  = ADDR_WIDTH'(4);

    // csr_in[15:12] are single-cycle pulses; csr_in[3:0] clear when the tile reads.
    localparam logic [CSR_IN_WIDTH-1:0]  IN_PULSE_MASK = CSR_IN_WIDTH'(16'hF000);
    localparam logic [CSR_IN_WIDTH-1:0]  IN_LOW_MASK   = CSR_IN_WIDTH'(16'h000F);
    localparam logic [CSR_OUT_WIDTH-1:0] OUT_LOW_MASK  = CSR_OUT_WIDTH'(16'h000F);

    logic [CSR_OUT_WIDTH-1:0] csr_out_r;
    logic [CSR_OUT_WIDTH-1:0] csr_out_next;
    logic [CSR_IN_WIDTH-1:0]  csr_in_next;
    logic [REG_WIDTH-1:0]     rd_mux;
    logic                     access_err;
    logic                     wr_ok;
    logic                     rd_ok;

    assign bus.bus_gnt = bus.bus_req;

    // Access decode: read-only targets and unmapped addresses error out and
    // suppress every state update.
    always_comb begin
        access_err = 1'b0;
        if (bus.bus_req) begin
            if (bus.bus_addr > ADDR_DATA_C) begin
                access_err = 1'b1;
            end else if (bus.bus_we &&
                         (bus.bus_addr == ADDR_CSR_OUT || bus.bus_addr == ADDR_DATA_C)) begin
                access_err = 1'b1;
            end
        end
        wr_ok = bus.bus_req &&  bus.bus_we && !access_err;
        rd_ok = bus.bus_req && !bus.bus_we && !access_err;
    end

    always_comb begin
        rd_mux = '0;
        case (bus.bus_addr)
            ADDR_CSR_IN:  rd_mux = REG_WIDTH'(csr_in);
            ADDR_CSR_OUT: rd_mux = REG_WIDTH'(csr_out_r);
            ADDR_DATA_A:  rd_mux = data_reg_a;
            ADDR_DATA_B:  rd_mux = data_reg_b;
            ADDR_DATA_C:  rd_mux = data_reg_c;
            default:      rd_mux = '0;
        endcase
    end

    // Lowest priority first so later assignments override.
    always_comb begin
        csr_in_next = csr_in & ~IN_PULSE_MASK;
        if (csr_in_re) begin
            csr_in_next = csr_in_next & ~IN_LOW_MASK;
        end
        if (wr_ok && bus.bus_addr == ADDR_CSR_IN) begin
            csr_in_next = bus.bus_wdata[CSR_IN_WIDTH-1:0];
        end
    end

    // A tile update on the same cycle as a clearing read is stored in full;
    // the read still returns the pre-update value from csr_out_r.
    always_comb begin
        csr_out_next = csr_out_r;
        if (rd_ok && bus.bus_addr == ADDR_CSR_OUT) begin
            csr_out_next = csr_out_r & ~OUT_LOW_MASK;
        end
        if (csr_out_we) begin
            csr_out_next = csr_out;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            csr_in         <= '0;
            data_reg_a     <= '0;
            data_reg_b     <= '0;
            csr_out_r      <= '0;
            irq            <= 1'b0;
            bus.bus_rvalid <= 1'b0;
            bus.bus_rdata  <= '0;
            bus.bus_err    <= 1'b0;
        end else begin
            csr_in    <= csr_in_next;
            csr_out_r <= csr_out_next;
            irq       <= |csr_out_next[3:0];
            if (wr_ok && bus.bus_addr == ADDR_DATA_A) begin
                data_reg_a <= bus.bus_wdata;
            end
            if (wr_ok && bus.bus_addr == ADDR_DATA_B) begin
                data_reg_b <= bus.bus_wdata;
            end
            bus.bus_rvalid <= bus.bus_req;
            bus.bus_err    <= access_err;
            bus.bus_rdata  <= rd_ok ? rd_mux : '0;
        end
    end

endmodule

// File: tb/tb_ip_tile_csr_bank.sv
module tb_ip_tile_csr_bank;

    typedef struct {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    localparam int NVEC = 16;

    logic        clk;
    logic        arst_n;
    logic [15:0] csr_in;
    logic        csr_in_re;
    logic [31:0] data_reg_a;
    logic [31:0] data_reg_b;
    logic [15:0] csr_out;
    logic        csr_out_we;
    logic [31:0] data_reg_c;
    logic        irq;

    int n_checks = 0;
    int n_err    = 0;
    resp_t exp_q[$];
    vec_t  vecs[NVEC];

    ip_tile_csr_bank_if #(.ADDR_WIDTH(4), .REG_WIDTH(32)) bus ();

    ip_tile_csr_bank #(
        .CSR_IN_WIDTH (16),
        .CSR_OUT_WIDTH(16),
        .REG_WIDTH    (32),
        .ADDR_WIDTH   (4)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .bus       (bus.slave),
        .csr_in    (csr_in),
        .csr_in_re (csr_in_re),
        .data_reg_a(data_reg_a),
        .data_reg_b(data_reg_b),
        .csr_out   (csr_out),
        .csr_out_we(csr_out_we),
        .data_reg_c(data_reg_c),
        .irq       (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic we, input logic [3:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rdata, input logic exp_err);
        resp_t r;
        bus.bus_req   = 1'b1;
        bus.bus_we    = we;
        bus.bus_addr  = addr;
        bus.bus_wdata = wdata;
        r.rdata = exp_rdata;
        r.err   = exp_err;
        exp_q.push_back(r);
    endtask

    task automatic idle();
        bus.bus_req   = 1'b0;
        bus.bus_we    = 1'b0;
        bus.bus_addr  = '0;
        bus.bus_wdata = '0;
    endtask

    task automatic post_check(input vec_t v);
        if (v.we && !v.exp_err && v.addr == 4'h2) check("data_reg_a_wr", data_reg_a, v.wdata);
        if (v.we && !v.exp_err && v.addr == 4'h3) check("data_reg_b_wr", data_reg_b, v.wdata);
    endtask

    // Scoreboard: every response must match the oldest outstanding access.
    always @(negedge clk) begin
        if (bus.bus_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_rvalid: got rvalid=1 expected no response (t=%0t)", $time);
            end else begin
                resp_t r;
                r = exp_q.pop_front();
                check("rdata", bus.bus_rdata, r.rdata);
                check("err", {31'd0, bus.bus_err}, {31'd0, r.err});
            end
        end
    end

    initial begin
        vecs[0]  = '{1'b0, 4'h0, 32'h0,        32'h0,        1'b0};
        vecs[1]  = '{1'b0, 4'h1, 32'h0,        32'h0,        1'b0};
        vecs[2]  = '{1'b0, 4'h2, 32'h0,        32'h0,        1'b0};
        vecs[3]  = '{1'b0, 4'h3, 32'h0,        32'h0,        1'b0};
        vecs[4]  = '{1'b0, 4'h4, 32'h0,        32'h0,        1'b0};
        vecs[5]  = '{1'b1, 4'h2, 32'hA5A5A5A5, 32'h0,        1'b0};
        vecs[6]  = '{1'b1, 4'h3, 32'h12A2A3A5, 32'h0,        1'b0};
        vecs[7]  = '{1'b0, 4'h2, 32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[8]  = '{1'b0, 4'h3, 32'h0,        32'h12A2A3A5, 1'b0};
        vecs[9]  = '{1'b1, 4'h4, 32'h11111111, 32'h0,        1'b1};
        vecs[10] = '{1'b0, 4'hF, 32'h0,        32'h0,        1'b1};
        vecs[11] = '{1'b1, 4'h1, 32'h0000FFFF, 32'h0,        1'b1};
        vecs[12] = '{1'b0, 4'h5, 32'h0,        32'h0,        1'b1};
        vecs[13] = '{1'b0, 4'h2, 32'h0,        32'hA5A5A5A5, 1'b0};
        vecs[14] = '{1'b0, 4'h3, 32'h0,        32'h12A2A3A5, 1'b0};
        vecs[15] = '{1'b0, 4'h1, 32'h0,        32'h0,        1'b0};

        arst_n     = 1'b0;
        csr_in_re  = 1'b0;
        csr_out    = '0;
        csr_out_we = 1'b0;
        data_reg_c = 32'h0;
        idle();
        #12;
        check("reset_rvalid", {31'd0, bus.bus_rvalid}, 32'd0);
        check("reset_csr_in", {16'd0, csr_in}, 32'd0);
        check("reset_data_a", data_reg_a, 32'd0);
        check("reset_data_b", data_reg_b, 32'd0);
        check("reset_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        arst_n = 1'b1;

        // Back-to-back table accesses; register side effects checked one cycle later.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            if (i > 0) post_check(vecs[i-1]);
            drive(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
            #1;
            check("gnt", {31'd0, bus.bus_gnt}, 32'd1);
        end
        @(negedge clk);
        post_check(vecs[NVEC-1]);
        idle();
        #1;
        check("gnt_idle", {31'd0, bus.bus_gnt}, 32'd0);
        check("irq_idle", {31'd0, irq}, 32'd0);

        // Pulse bits last one cycle; tile read clears the low nibble.
        @(negedge clk);
        drive(1'b1, 4'h0, 32'h000081F5, 32'h0, 1'b0);
        @(negedge clk);
        idle();
        check("csr_in_pulse", {16'd0, csr_in}, 32'h81F5);
        @(negedge clk);
        check("csr_in_after_pulse", {16'd0, csr_in}, 32'h01F5);
        csr_in_re = 1'b1;
        @(negedge clk);
        csr_in_re = 1'b0;
        check("csr_in_re_clear", {16'd0, csr_in}, 32'h01F0);
        drive(1'b0, 4'h0, 32'h0, 32'h000001F0, 1'b0);
        @(negedge clk);
        idle();

        // Write and tile read strobe on the same cycle: the write wins.
        @(negedge clk);
        drive(1'b1, 4'h0, 32'h0000002C, 32'h0, 1'b0);
        csr_in_re = 1'b1;
        @(negedge clk);
        idle();
        csr_in_re = 1'b0;
        check("csr_in_write_beats_re", {16'd0, csr_in}, 32'h002C);

        // Status capture, irq, clear-on-read.
        @(negedge clk);
        data_reg_c = 32'hCAFE0123;
        csr_out    = 16'h0305;
        csr_out_we = 1'b1;
        @(negedge clk);
        csr_out_we = 1'b0;
        check("irq_set", {31'd0, irq}, 32'd1);
        drive(1'b0, 4'h1, 32'h0, 32'h00000305, 1'b0);
        @(negedge clk);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        drive(1'b0, 4'h1, 32'h0, 32'h00000300, 1'b0);
        @(negedge clk);
        drive(1'b0, 4'h4, 32'h0, 32'hCAFE0123, 1'b0);
        @(negedge clk);
        idle();

        // Tile update colliding with a clearing read.
        @(negedge clk);
        csr_out    = 16'h0001;
        csr_out_we = 1'b1;
        @(negedge clk);
        check("irq_before_collide", {31'd0, irq}, 32'd1);
        csr_out = 16'h000A;
        drive(1'b0, 4'h1, 32'h0, 32'h00000001, 1'b0);
        @(negedge clk);
        csr_out_we = 1'b0;
        idle();
        check("irq_after_collide", {31'd0, irq}, 32'd1);
        @(negedge clk);
        drive(1'b0, 4'h1, 32'h0, 32'h0000000A, 1'b0);
        @(negedge clk);
        idle();
        check("irq_after_final_read", {31'd0, irq}, 32'd0);

        // Reset lands while a response is pending.
        @(negedge clk);
        drive(1'b1, 4'h3, 32'hDEADBEEF, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_rvalid", {31'd0, bus.bus_rvalid}, 32'd0);
        check("midrst_rdata", bus.bus_rdata, 32'd0);
        check("midrst_err", {31'd0, bus.bus_err}, 32'd0);
        check("midrst_csr_in", {16'd0, csr_in}, 32'd0);
        check("midrst_data_a", data_reg_a, 32'd0);
        check("midrst_data_b", data_reg_b, 32'd0);
        check("midrst_irq", {31'd0, irq}, 32'd0);
        @(negedge clk);
        idle();
        arst_n = 1'b1;
        @(negedge clk);
        drive(1'b0, 4'h1, 32'h0, 32'h0, 1'b0);
        @(negedge clk);
        idle();
        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ip_tile_csr_bank.md
Name: ip_tile_csr_bank

Overview:
Bus-facing register bank that sits directly upstream of the ip_tile_fsm_bitwise_shifter tile. It holds csr_in, data_reg_a and data_reg_b, and drives them into the tile. It captures the tile's csr_out status and exposes data_reg_c for reads. It owns the single-pulse semantics of csr_in[15:12] and the clear-on-read semantics of csr_in[3:0] and csr_out[3:0], plus a status interrupt.

Parameters:
CSR_IN_WIDTH, 16, width of the command CSR driven to the tile
CSR_OUT_WIDTH, 16, width of the status CSR from the tile
REG_WIDTH, 32, width of the data registers and of the bus data
ADDR_WIDTH, 4, bus word-address width

Ports:
clk  in  1  clock
arst_n  in  1  asynchronous active-low reset
bus_req  in  1  access request
bus_we  in  1  1 = write, 0 = read
bus_addr  in  ADDR_WIDTH  word address
bus_wdata  in  REG_WIDTH  write data
bus_gnt  out  1  request accepted
bus_rvalid  out  1  response valid (reads and writes)
bus_rdata  out  REG_WIDTH  read data, valid with bus_rvalid
bus_err  out  1  error flag, valid with bus_rvalid
csr_in  out  CSR_IN_WIDTH  command CSR to the tile
csr_in_re  in  1  tile read strobe for csr_in
data_reg_a  out  REG_WIDTH  operand A to the tile
data_reg_b  out  REG_WIDTH  operand B to the tile
csr_out  in  CSR_OUT_WIDTH  status from the tile
csr_out_we  in  1  tile write strobe for status
data_reg_c  in  REG_WIDTH  result from the tile
irq  out  1  status interrupt

Behaviour:
- Reset: arst_n is asynchronous and active-low; clock is clk. On reset, all registers and outputs go to 0: csr_in, data_reg_a, data_reg_b, the csr_out_r shadow, bus_rvalid, bus_rdata, bus_err and irq.
- Address map:
  - 0x0 CSR_IN: RW.
  - 0x1 CSR_OUT: RO, clear-on-read for bits [3:0].
  - 0x2 DATA_A: RW.
  - 0x3 DATA_B: RW.
  - 0x4 DATA_C: RO, reads the live data_reg_c input.
  - 0x5-0xF: unmapped.
- Field widths: CSR fields are zero-extended on read. On write, the low CSR_IN_WIDTH bits are used.
- Handshake:
  - bus_gnt = bus_req (combinational); one access per cycle, no wait states.
  - An accepted access at edge N produces bus_rvalid=1 for exactly one cycle after edge N+1.
  - bus_rdata and bus_err are registered with it. bus_rdata is 0 for writes and on error.
- Errors: bus_err=1 on a write to 0x1 or 0x4, or any access to an unmapped address. An erroring access changes no state.
- csr_in register, per cycle, in priority order:
  - (1) An accepted bus write to 0x0 loads all bits.
  - (2) Otherwise bits [15:12] clear to 0, so a written pulse bit is high for exactly one cycle.
  - (3) Otherwise, if csr_in_re=1, bits [3:0] also clear.
  - (4) Bits [11:4] hold.
  - A bus write on the same cycle as csr_in_re: the write wins.
- csr_out_r shadow:
  - If csr_out_we=1, it loads csr_out.
  - Otherwise, on an accepted bus read of 0x1, bits [3:0] clear.
  - The read returns the value before the clear.
  - csr_out_we on the same cycle as a read of 0x1: the read returns the old value; the new value is stored in full (no clear).
- DATA_A / DATA_B: load on an accepted write; the written value is visible on data_reg_a / data_reg_b the next cycle.
- DATA_C read: samples data_reg_c at the accept edge.
- irq:
  - Registered; irq = |csr_out_r[3:0] as computed after the current update.
  - Asserts one cycle after a csr_out_we that sets any of bits [3:0].
  - Deasserts one cycle after a clearing read.
- Back-to-back accesses: fully pipelined. The response to access N and the acceptance of access N+1 may occur in the same cycle.
- Reset mid-transaction: a pending response is dropped (bus_rvalid returns to 0 immediately) and all state is cleared.

Test Plan:
- Reset, then read addresses 0x0-0x4 -> every access returns bus_rvalid=1, bus_rdata=0, bus_err=0; irq=0.
- Write DATA_A=0xA5A5A5A5 and DATA_B=0x12A2A3A5, then read both back -> data_reg_a and data_reg_b match the written values one cycle after each write; the reads return the same values.
- Write CSR_IN=0x81F5 -> csr_in=0x81F5 for one cycle, then 0x01F5 (pulse bits gone). Pulse csr_in_re -> csr_in=0x01F0. Read 0x0 -> 0x000001F0.
- Tile asserts csr_out_we with csr_out=0x0305 -> irq=1 one cycle later. First read of 0x1 returns 0x00000305; a second read returns 0x00000300; irq=0 after the first read.
- Same-cycle csr_out_we with 0x000A and a bus read of 0x1 (shadow holding 0x0001) -> the read returns 0x00000001, the shadow becomes 0x000A, irq stays 1.
- Write to 0x4 and read 0xF -> bus_err=1 and bus_rdata=0 on both; no register changes. Assert arst_n=0 between accept and response -> no bus_rvalid, all outputs 0.
